// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified instruction/data memory port arbiter.
// Holds the read-owner tag encoding and the byte-to-word address shift.
// Also provides the helper that maps this cycle's grants onto the next read owner.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

  // Byte address to word address: the RAM holds 32-bit words.
  localparam int WORD_SHIFT = 2;

  // Owner of the read data returning next cycle; writes and idle cycles leave no owner.
  function automatic owner_t next_owner(input logic if_gnt, input logic d_gnt, input logic d_we);
    owner_t own;
    own = OWN_NONE;
    if (if_gnt) begin
      own = OWN_IF;
    end else if (d_gnt && !d_we) begin
      own = OWN_D;
    end
    return own;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, the load/store port and the RAM side of the arbiter.
// The arbiter uses the slave view; the core plus memory model use the master view.
// Request signals are held by the requester until the matching grant.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 10
) ();

  // Instruction-fetch port
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  // Load/store port
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  // Memory array side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive cycles the fetch port asked and lost; flags when the limit is reached.
// Latency: count updates on the clock edge, the limit flag is a registered compare.
// Backpressure: none; it only observes the fetch request and grant.
module mem_arb_starve_ctr #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req_i,
  input  logic if_gnt_i,
  output logic starve_o
);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: clear whenever fetch is served or stops asking, otherwise step up to the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (!if_req_i || if_gnt_i) begin
      cnt_d = 4'd0;
    end else if (cnt_q != 4'(STARVE_MAX)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign starve_o = (cnt_q == 4'(STARVE_MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word RAM between fetch and load/store; data wins unless fetch is starved.
// Latency: grant and RAM strobe in the request cycle; read data returns to its owner one cycle later.
// Backpressure: a losing requester keeps its request held; grants may issue every cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  mem_port_arbiter_if.slave bus,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             if_gnt_c;
  logic             d_gnt_c;
  logic             starve_hit;
  owner_t           tag_q;
  owner_t           tag_d;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic             if_rvalid_c;
  logic             d_rvalid_c;
  logic             unused_addr_bits;

  mem_arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .if_req_i (bus.if_req),
    .if_gnt_i (if_gnt_c),
    .starve_o (starve_hit)
  );

  // Fixed priority with starvation override; nothing is granted while reset is held.
  always_comb begin
    if_gnt_c = 1'b0;
    d_gnt_c  = 1'b0;
    if (!reset) begin
      if (starve_hit && bus.if_req) begin
        if_gnt_c = 1'b1;
      end else if (bus.d_req) begin
        d_gnt_c = 1'b1;
      end else if (bus.if_req) begin
        if_gnt_c = 1'b1;
      end
    end
  end

  // The winner drives the RAM in the same cycle; an idle RAM side is held at zero.
  always_comb begin
    bus.mem_en    = if_gnt_c | d_gnt_c;
    bus.mem_we    = d_gnt_c & bus.d_we;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (d_gnt_c) begin
      bus.mem_addr  = bus.d_addr[ADDR_W+WORD_SHIFT-1:WORD_SHIFT];
      bus.mem_wdata = bus.d_wdata;
    end else if (if_gnt_c) begin
      bus.mem_addr  = bus.if_addr[ADDR_W+WORD_SHIFT-1:WORD_SHIFT];
    end
  end

  // Byte-lane and out-of-range address bits play no part in a word RAM of this depth.
  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+WORD_SHIFT], bus.if_addr[WORD_SHIFT-1:0],
                              bus.d_addr[31:ADDR_W+WORD_SHIFT],  bus.d_addr[WORD_SHIFT-1:0]};

  // Owner of next cycle's read data follows this cycle's grant.
  always_comb begin
    tag_d = next_owner(if_gnt_c, d_gnt_c, bus.d_we);
  end

  // Stall counter steps on every lost fetch cycle and sticks at all-ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.if_req && !if_gnt_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // Pending-read tag and stall counter; reset drops any outstanding read.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_q       <= OWN_NONE;
      stall_cnt_q <= '0;
    end else begin
      tag_q       <= tag_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Returned data goes only to its owner; a read in flight when reset rises is not delivered.
  always_comb begin
    if_rvalid_c  = (tag_q == OWN_IF) && !reset;
    d_rvalid_c   = (tag_q == OWN_D)  && !reset;
    bus.if_rvalid = if_rvalid_c;
    bus.d_rvalid  = d_rvalid_c;
    bus.if_rdata  = if_rvalid_c ? bus.mem_rdata : 32'd0;
    bus.d_rdata   = d_rvalid_c  ? bus.mem_rdata : 32'd0;
  end

  assign bus.if_gnt = if_gnt_c;
  assign bus.d_gnt  = d_gnt_c;
  assign stall_cnt  = stall_cnt_q;

endmodule
